// File: rtl/dtw_pkg.sv
// Shared definitions for the DTW result path: result entry layout,
// packet terminator word and the packer state encoding.
package dtw_pkg;

  // One result entry as buffered between dtw_core and the stream packer.
  localparam int DTW_RES_W = 96;

  // Payload of the packet-closing beat emitted on a flush.
  localparam logic [31:0] DTW_TERM_WORD = 32'hFFFF_FFFF;

  // Field order matches the beat order on the stream: qid, minval, position.
  typedef struct packed {
    logic [31:0] qid;
    logic [31:0] minval;
    logic [31:0] position;
  } dtw_res_t;

  // Packer states: idle, the three payload beats, and the flush terminator.
  typedef enum logic [2:0] {
    ST_IDLE = 3'd0,
    ST_QID  = 3'd1,
    ST_MIN  = 3'd2,
    ST_POS  = 3'd3,
    ST_TERM = 3'd4
  } pkt_state_e;

  // Width of a counter holding 0..n-1, never narrower than one bit.
  function automatic int pkt_cnt_width(input int n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/dtw_result_axis_packer_if.sv
// AXI4-Stream link carrying packed DTW results towards the DMA S2MM channel.
interface dtw_result_axis_packer_if #(
  parameter int DATA_W = 32
);

  logic                  tvalid;
  logic [DATA_W-1:0]     tdata;
  logic [DATA_W/8-1:0]   tstrb;
  logic                  tlast;
  logic                  tready;

  // Packer side drives the beat, consumer returns ready.
  modport master (
    output tvalid,
    output tdata,
    output tstrb,
    output tlast,
    input  tready
  );

  // Consumer side (DMA or a bench).
  modport slave (
    input  tvalid,
    input  tdata,
    input  tstrb,
    input  tlast,
    output tready
  );

endinterface

// File: rtl/dtw_result_fifo.sv
// Synchronous result FIFO with registered full/empty and a registered read
// port: rd_data shows the popped entry from the cycle after rd_en. rd_data
// holds its value until the next accepted pop, so the packer uses it
// directly as its hold register.
module dtw_result_fifo
  import dtw_pkg::*;
#(
  parameter int DEPTH = 16,          // power of two, >= 2
  parameter int WIDTH = DTW_RES_W
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             wr_en,
  input  logic [WIDTH-1:0] wr_data,
  input  logic             rd_en,
  output logic [WIDTH-1:0] rd_data,
  output logic             full,
  output logic             empty
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr_reg;
  logic [AW-1:0]    rd_ptr_reg;
  logic [CW-1:0]    count_reg;
  logic [CW-1:0]    count_next;
  logic             full_reg;
  logic             empty_reg;
  logic [WIDTH-1:0] rd_data_reg;
  logic             wr_accept;
  logic             rd_accept;

  // Writes while full and reads while empty are ignored here; the caller
  // decides what a refused write means.
  assign wr_accept = wr_en && !full_reg;
  assign rd_accept = rd_en && !empty_reg;

  // Occupancy after this cycle; a simultaneous push and pop leaves it unchanged.
  always_comb begin
    count_next = count_reg;
    case ({wr_accept, rd_accept})
      2'b10:   count_next = count_reg + CW'(1);
      2'b01:   count_next = count_reg - CW'(1);
      default: count_next = count_reg;
    endcase
  end

  // Pointers, occupancy and the registered status flags.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_reg <= '0;
      rd_ptr_reg <= '0;
      count_reg  <= '0;
      full_reg   <= 1'b0;
      empty_reg  <= 1'b1;
    end else begin
      if (wr_accept) wr_ptr_reg <= wr_ptr_reg + AW'(1);
      if (rd_accept) rd_ptr_reg <= rd_ptr_reg + AW'(1);
      count_reg <= count_next;
      full_reg  <= (count_next == CW'(DEPTH));
      empty_reg <= (count_next == '0);
    end
  end

  // Storage array, written without reset so it maps onto block RAM.
  always_ff @(posedge clk) begin
    if (wr_accept) mem[wr_ptr_reg] <= wr_data;
  end

  // Registered read port: the popped entry appears one cycle after rd_en.
  always_ff @(posedge clk) begin
    if (rd_accept) rd_data_reg <= mem[rd_ptr_reg];
  end

  assign rd_data = rd_data_reg;
  assign full    = full_reg;
  assign empty   = empty_reg;

endmodule

// File: rtl/dtw_result_axis_packer.sv
// Buffers dtw_core results and serialises each one as three 32-bit beats
// (qid, minval, position) on an AXI4-Stream master. TLAST closes a packet
// every RESULTS_PER_PKT results, or via a terminator beat after a flush.
module dtw_result_axis_packer
  import dtw_pkg::*;
#(
  parameter int C_M_AXIS_TDATA_WIDTH = 32,   // only 32 is supported
  parameter int FIFO_DEPTH           = 16,   // power of two, >= 2
  parameter int RESULTS_PER_PKT      = 4     // >= 1
) (
  input  logic        M_AXIS_ACLK,
  input  logic        M_AXIS_ARESETN,
  input  logic        dtw_fifo_wren,
  input  logic [31:0] dtw_minval,
  input  logic [31:0] dtw_position,
  input  logic [31:0] dtw_qid,
  input  logic        dtw_flush,
  output logic        dtw_fifo_full,
  output logic        dtw_overflow,
  output logic [31:0] dtw_results_sent,
  dtw_result_axis_packer_if.master m_axis
);

  localparam int PKT_W = pkt_cnt_width(RESULTS_PER_PKT);
  localparam logic [PKT_W-1:0] PKT_LAST = PKT_W'(RESULTS_PER_PKT - 1);

  logic [1:0]                       rst_sync_reg;
  logic                             rst_n_int;

  pkt_state_e                       state_reg;
  pkt_state_e                       state_next;
  logic [PKT_W-1:0]                 res_in_pkt_reg;
  logic [PKT_W-1:0]                 res_in_pkt_next;
  logic                             flush_pending_reg;
  logic                             flush_pending_next;
  logic [31:0]                      results_sent_reg;
  logic [31:0]                      results_sent_next;
  logic                             overflow_reg;

  dtw_res_t                         wr_entry;
  dtw_res_t                         hold_res;
  logic                             fifo_pop;
  logic                             fifo_full;
  logic                             fifo_empty;

  logic                             tvalid_next;
  logic [C_M_AXIS_TDATA_WIDTH-1:0]  tdata_next;
  logic                             tlast_next;

  // Reset asserts asynchronously but is released on a clock edge, so all
  // state leaves reset in the same cycle.
  always_ff @(posedge M_AXIS_ACLK or negedge M_AXIS_ARESETN) begin
    if (!M_AXIS_ARESETN) rst_sync_reg <= 2'b00;
    else                 rst_sync_reg <= {rst_sync_reg[0], 1'b1};
  end

  assign rst_n_int = rst_sync_reg[1];

  assign wr_entry = {dtw_qid, dtw_minval, dtw_position};

  dtw_result_fifo #(
    .DEPTH (FIFO_DEPTH),
    .WIDTH (DTW_RES_W)
  ) u_fifo (
    .clk     (M_AXIS_ACLK),
    .rst_n   (rst_n_int),
    .wr_en   (dtw_fifo_wren),
    .wr_data (wr_entry),
    .rd_en   (fifo_pop),
    .rd_data (hold_res),
    .full    (fifo_full),
    .empty   (fifo_empty)
  );

  // Packer FSM: beat selection, pops and packet bookkeeping. Outputs depend
  // only on registered state, so they stay stable while TREADY is low.
  always_comb begin
    state_next         = state_reg;
    res_in_pkt_next    = res_in_pkt_reg;
    flush_pending_next = flush_pending_reg;
    results_sent_next  = results_sent_reg;
    fifo_pop           = 1'b0;
    tvalid_next        = 1'b0;
    tdata_next         = '0;
    tlast_next         = 1'b0;

    case (state_reg)
      ST_IDLE: begin
        // Pending results always go before a flush takes effect.
        if (!fifo_empty) begin
          fifo_pop   = 1'b1;
          state_next = ST_QID;
        end else if (flush_pending_reg) begin
          if (res_in_pkt_reg != '0) state_next = ST_TERM;
          else                      flush_pending_next = 1'b0;
        end
      end

      ST_QID: begin
        tvalid_next = 1'b1;
        tdata_next  = hold_res.qid;
        if (m_axis.tready) state_next = ST_MIN;
      end

      ST_MIN: begin
        tvalid_next = 1'b1;
        tdata_next  = hold_res.minval;
        if (m_axis.tready) state_next = ST_POS;
      end

      ST_POS: begin
        tvalid_next = 1'b1;
        tdata_next  = hold_res.position;
        tlast_next  = (res_in_pkt_reg == PKT_LAST);
        if (m_axis.tready) begin
          results_sent_next = results_sent_reg + 32'd1;
          res_in_pkt_next   = (res_in_pkt_reg == PKT_LAST) ? '0
                                                           : res_in_pkt_reg + PKT_W'(1);
          // Chain straight into the next result to avoid an idle cycle.
          if (!fifo_empty) begin
            fifo_pop   = 1'b1;
            state_next = ST_QID;
          end else begin
            state_next = ST_IDLE;
          end
        end
      end

      ST_TERM: begin
        tvalid_next = 1'b1;
        tdata_next  = DTW_TERM_WORD;
        tlast_next  = 1'b1;
        if (m_axis.tready) begin
          res_in_pkt_next    = '0;
          flush_pending_next = 1'b0;
          state_next         = ST_IDLE;
        end
      end

      default: state_next = ST_IDLE;
    endcase

    // A new flush request is never lost, even when one is being retired.
    if (dtw_flush) flush_pending_next = 1'b1;
  end

  // Packer state, packet position, flush request and sent-result counter.
  always_ff @(posedge M_AXIS_ACLK or negedge rst_n_int) begin
    if (!rst_n_int) begin
      state_reg         <= ST_IDLE;
      res_in_pkt_reg    <= '0;
      flush_pending_reg <= 1'b0;
      results_sent_reg  <= '0;
    end else begin
      state_reg         <= state_next;
      res_in_pkt_reg    <= res_in_pkt_next;
      flush_pending_reg <= flush_pending_next;
      results_sent_reg  <= results_sent_next;
    end
  end

  // Sticky drop flag: any write refused because the buffer was full.
  always_ff @(posedge M_AXIS_ACLK or negedge rst_n_int) begin
    if (!rst_n_int)                      overflow_reg <= 1'b0;
    else if (dtw_fifo_wren && fifo_full) overflow_reg <= 1'b1;
  end

  assign m_axis.tvalid    = tvalid_next;
  assign m_axis.tdata     = tdata_next;
  assign m_axis.tlast     = tlast_next;
  assign m_axis.tstrb     = '1;

  assign dtw_fifo_full    = fifo_full;
  assign dtw_overflow     = overflow_reg;
  assign dtw_results_sent = results_sent_reg;

endmodule

// File: tb/tb_dtw_result_axis_packer.sv
// Scoreboard bench for dtw_result_axis_packer: each accepted result pushes
// its three expected beats (and flushes push a terminator) into a queue that
// the stream monitor pops on every handshake.
module tb_dtw_result_axis_packer;

  localparam int DEPTH = 16;
  localparam int RPP   = 4;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        wren;
  logic        flush;
  logic [31:0] minval;
  logic [31:0] position;
  logic [31:0] qid;
  logic        full;
  logic        overflow;
  logic [31:0] sent;

  dtw_result_axis_packer_if #(.DATA_W(32)) m_axis ();

  dtw_result_axis_packer #(
    .C_M_AXIS_TDATA_WIDTH (32),
    .FIFO_DEPTH           (DEPTH),
    .RESULTS_PER_PKT      (RPP)
  ) dut (
    .M_AXIS_ACLK      (clk),
    .M_AXIS_ARESETN   (rst_n),
    .dtw_fifo_wren    (wren),
    .dtw_minval       (minval),
    .dtw_position     (position),
    .dtw_qid          (qid),
    .dtw_flush        (flush),
    .dtw_fifo_full    (full),
    .dtw_overflow     (overflow),
    .dtw_results_sent (sent),
    .m_axis           (m_axis)
  );

  always #5 clk = ~clk;

  int          total = 0;
  int          bad = 0;
  logic [32:0] exp_q[$];
  int          model_pkt = 0;
  int          model_sent = 0;
  int          hs_count = 0;
  int          cyc_cnt = 0;
  int          first_hs = -1;
  int          last_hs = 0;
  logic        stall_prev = 1'b0;
  logic [32:0] prev_beat = '0;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  always @(posedge clk) cyc_cnt++;

  // Stream monitor: hold rules while stalled, scoreboard pop on handshake.
  always @(negedge clk) begin
    if (!rst_n) begin
      stall_prev = 1'b0;
    end else begin
      if (stall_prev) begin
        chk("hold_valid", m_axis.tvalid, 1);
        chk("hold_beat", {m_axis.tlast, m_axis.tdata}, prev_beat);
      end
      if (m_axis.tvalid && m_axis.tready) begin
        $display("beat %0d data=%08h last=%0b", hs_count, m_axis.tdata, m_axis.tlast);
        if (exp_q.size() == 0) chk("beat_avail", exp_q.size(), 1);
        else chk("beat", {m_axis.tlast, m_axis.tdata}, exp_q.pop_front());
        hs_count++;
        if (first_hs < 0) first_hs = cyc_cnt;
        last_hs = cyc_cnt;
      end
      stall_prev = m_axis.tvalid && !m_axis.tready;
      prev_beat  = {m_axis.tlast, m_axis.tdata};
    end
  end

  // Drive one result for one cycle; expected beats are queued if it is accepted.
  task automatic write_res(input logic [31:0] q, input logic [31:0] m,
                           input logic [31:0] p, input bit accept);
    logic lastb;
    wren = 1'b1; qid = q; minval = m; position = p;
    if (accept) begin
      lastb = (model_pkt == RPP - 1);
      exp_q.push_back({1'b0, q});
      exp_q.push_back({1'b0, m});
      exp_q.push_back({lastb, p});
      model_pkt = lastb ? 0 : model_pkt + 1;
      model_sent++;
    end
    @(posedge clk); #1;
    wren = 1'b0;
  endtask

  task automatic do_flush();
    flush = 1'b1;
    if (model_pkt != 0) begin
      exp_q.push_back({1'b1, 32'hFFFF_FFFF});
      model_pkt = 0;
    end
    @(posedge clk); #1;
    flush = 1'b0;
  endtask

  task automatic wait_drain(input string tag);
    int n = 0;
    while ((exp_q.size() != 0 || m_axis.tvalid) && n < 2000) begin
      @(posedge clk); #1;
      n++;
    end
    chk(tag, exp_q.size(), 0);
    chk({tag, "_idle"}, m_axis.tvalid, 0);
  endtask

  task automatic wait_valid(input string tag);
    int n = 0;
    while (!m_axis.tvalid && n < 50) begin
      @(posedge clk); #1;
      n++;
    end
    chk(tag, m_axis.tvalid, 1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got=timeout exp=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic [31:0] q, m, p;
    int hs0;
    wren = 1'b0; flush = 1'b0; qid = '0; minval = '0; position = '0;
    m_axis.tready = 1'b0;
    rst_n = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_tvalid", m_axis.tvalid, 0);
    chk("rst_tlast", m_axis.tlast, 0);
    chk("rst_tdata", m_axis.tdata, 0);
    chk("rst_tstrb", m_axis.tstrb, 4'hF);
    chk("rst_full", full, 0);
    chk("rst_overflow", overflow, 0);
    chk("rst_sent", sent, 0);
    rst_n = 1'b1;
    repeat (4) @(posedge clk);
    #1;

    // Single result: first beat two cycles after the write cycle.
    m_axis.tready = 1'b1;
    q = 32'h1000_0001; m = $urandom; p = $urandom;
    write_res(q, m, p, 1);
    chk("lat_n1_tvalid", m_axis.tvalid, 0);
    @(posedge clk); #1;
    chk("lat_n2_tvalid", m_axis.tvalid, 1);
    chk("lat_n2_qid", m_axis.tdata, q);
    wait_drain("t1_drain");
    chk("t1_sent", sent, model_sent);
    do_flush();
    wait_drain("t1_flush");

    // Four back-to-back results: twelve contiguous beats.
    first_hs = -1;
    hs0 = hs_count;
    for (int k = 0; k < 4; k++) write_res(32'h2000_0000 + k, $urandom, $urandom, 1);
    wait_drain("b2b_drain");
    chk("b2b_beats", hs_count - hs0, 12);
    chk("b2b_span", last_hs - first_hs + 1, 12);
    chk("b2b_sent", sent, model_sent);

    // Ten-cycle stall on the minval beat.
    m_axis.tready = 1'b0;
    q = 32'h3000_0001; m = $urandom; p = $urandom;
    write_res(q, m, p, 1);
    wait_valid("stall_valid");
    m_axis.tready = 1'b1;
    @(posedge clk); #1;
    m_axis.tready = 1'b0;
    chk("stall_min", m_axis.tdata, m);
    repeat (10) @(posedge clk);
    #1;
    chk("stall_min_held", m_axis.tdata, m);
    chk("stall_valid_held", m_axis.tvalid, 1);
    m_axis.tready = 1'b1;
    wait_drain("stall_drain");
    chk("stall_sent", sent, model_sent);

    // Overflow: buffer plus hold register take DEPTH+1 results, next is dropped.
    m_axis.tready = 1'b0;
    chk("ovf_pre", overflow, 0);
    for (int i = 0; i < DEPTH + 2; i++) begin
      if (i == DEPTH)     chk("full_before_last_fit", full, 0);
      if (i == DEPTH + 1) chk("full_at_capacity", full, 1);
      write_res(32'h4000_0000 + i, $urandom, $urandom, i < DEPTH + 1);
    end
    chk("overflow_set", overflow, 1);
    m_axis.tready = 1'b1;
    wait_drain("ovf_drain");
    chk("ovf_full_clear", full, 0);
    chk("ovf_sent", sent, model_sent);
    do_flush();
    wait_drain("ovf_flush");

    // Two results then flush: six beats, then the terminator with TLAST.
    hs0 = hs_count;
    write_res(32'h5000_0001, $urandom, $urandom, 1);
    write_res(32'h5000_0002, $urandom, $urandom, 1);
    do_flush();
    wait_drain("flush_drain");
    chk("flush_beats", hs_count - hs0, 7);

    // Flush with no open packet emits nothing.
    hs0 = hs_count;
    do_flush();
    repeat (10) @(posedge clk);
    #1;
    chk("empty_flush_beats", hs_count - hs0, 0);
    chk("empty_flush_tvalid", m_axis.tvalid, 0);

    // Reset during the position beat of the third result in a packet.
    write_res(32'h6000_0001, $urandom, $urandom, 1);
    write_res(32'h6000_0002, $urandom, $urandom, 1);
    wait_drain("pre_rst_drain");
    m_axis.tready = 1'b0;
    q = 32'h6000_0003; m = $urandom; p = $urandom;
    write_res(q, m, p, 1);
    wait_valid("pre_rst_valid");
    m_axis.tready = 1'b1;
    @(posedge clk); #1;
    @(posedge clk); #1;
    m_axis.tready = 1'b0;
    chk("pos_before_rst", m_axis.tdata, p);
    #2;
    rst_n = 1'b0;
    #1;
    chk("mid_rst_tvalid", m_axis.tvalid, 0);
    chk("mid_rst_tlast", m_axis.tlast, 0);
    chk("mid_rst_tdata", m_axis.tdata, 0);
    chk("mid_rst_sent", sent, 0);
    chk("mid_rst_overflow", overflow, 0);
    chk("mid_rst_full", full, 0);
    exp_q.delete();
    model_pkt = 0;
    model_sent = 0;
    @(posedge clk); #1;
    rst_n = 1'b1;
    repeat (4) @(posedge clk);
    #1;
    m_axis.tready = 1'b1;
    for (int k = 0; k < 4; k++) write_res(32'h7000_0000 + k, $urandom, $urandom, 1);
    wait_drain("post_rst_drain");
    chk("post_rst_sent", sent, model_sent);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
